// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback logic of the pipelined RV64 core.
// It captures MEM-stage results, extends load data, drives the regfile write
// port, the difftest retire PC, the decode bypass tap and the instret counter.
// An instruction retires only in its first WB cycle, so stalls never replay it.
module mem_wb_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               rd_we_i,
  input  logic [XLEN-1:0]    alu_res_i,
  input  logic               is_load_i,
  input  logic [1:0]         ld_size_i,
  input  logic               ld_unsigned_i,
  input  logic [2:0]         addr_lo_i,
  input  logic [XLEN-1:0]    mem_rdata_i,
  output logic [RADDR_W-1:0] wr_addr_o,
  output logic [XLEN-1:0]    wr_data_o,
  output logic               wr_en_o,
  output logic [XLEN-1:0]    pc_wb_o,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]    fwd_data_o,
  output logic [63:0]        instret_o
);

  // Shift the doubleword down to the addressed byte, then keep and extend
  // the low 8/16/32/64 bits. Bytes shifted in from above bit 63 are zero.
  function automatic logic [XLEN-1:0] load_ext(
    input logic [XLEN-1:0] rdata,
    input logic [2:0]      lo,
    input logic [1:0]      size,
    input logic            uns
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {lo, 3'b000};
    case (size)
      2'b00:   res = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      2'b01:   res = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      2'b10:   res = {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  logic               valid_p1;
  logic               done_p1;
  logic [XLEN-1:0]    pc_p1;
  logic [RADDR_W-1:0] rd_p1;
  logic               we_p1;
  logic [XLEN-1:0]    alu_p1;
  logic               ld_p1;
  logic [1:0]         size_p1;
  logic               uns_p1;
  logic [2:0]         lo_p1;
  logic [XLEN-1:0]    rdata_p1;
  logic [63:0]        instret_p1;

  logic               retire;
  logic               rd_nz;
  logic [XLEN-1:0]    wb_data;

  // MEM -> WB boundary: reset, then flush, then stall hold, else capture
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_p1 <= 1'b0;
      done_p1  <= 1'b0;
      pc_p1    <= '0;
      rd_p1    <= '0;
      we_p1    <= 1'b0;
      alu_p1   <= '0;
      ld_p1    <= 1'b0;
      size_p1  <= '0;
      uns_p1   <= 1'b0;
      lo_p1    <= '0;
      rdata_p1 <= '0;
    end else if (flush_i) begin
      valid_p1 <= 1'b0;
      done_p1  <= 1'b0;
    end else if (stall_i) begin
      // The held instruction has had its retire cycle once valid_p1 was seen
      done_p1  <= valid_p1;
    end else begin
      valid_p1 <= valid_i;
      done_p1  <= 1'b0;
      pc_p1    <= pc_i;
      rd_p1    <= rd_addr_i;
      we_p1    <= rd_we_i;
      alu_p1   <= alu_res_i;
      ld_p1    <= is_load_i;
      size_p1  <= ld_size_i;
      uns_p1   <= ld_unsigned_i;
      lo_p1    <= addr_lo_i;
      rdata_p1 <= mem_rdata_i;
    end
  end

  // Count each retirement once; a retire coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_p1 <= '0;
    end else if (retire) begin
      instret_p1 <= instret_p1 + 64'd1;
    end
  end

  // WB stage outputs, combinational from the registered fields
  always_comb begin
    retire  = valid_p1 & ~done_p1;
    rd_nz   = (rd_p1 != '0);
    wb_data = ld_p1 ? load_ext(rdata_p1, lo_p1, size_p1, uns_p1) : alu_p1;
  end

  assign wr_addr_o   = rd_p1;
  assign wr_data_o   = wb_data;
  assign wr_en_o     = retire & we_p1 & rd_nz;
  assign pc_wb_o     = retire ? pc_p1 : '0;
  assign fwd_valid_o = valid_p1 & we_p1 & rd_nz;
  assign fwd_addr_o  = rd_p1;
  assign fwd_data_o  = wb_data;
  assign instret_o   = instret_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the WB slot.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [63:0] pc_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic [63:0] alu_res_i = '0;
  logic        is_load_i = 1'b0;
  logic [1:0]  ld_size_i = '0;
  logic        ld_unsigned_i = 1'b0;
  logic [2:0]  addr_lo_i = '0;
  logic [63:0] mem_rdata_i = '0;
  logic [4:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic        wr_en_o;
  logic [63:0] pc_wb_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [63:0] fwd_data_o;
  logic [63:0] instret_o;

  mem_wb_stage #(.XLEN(64), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .pc_i(pc_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .alu_res_i(alu_res_i), .is_load_i(is_load_i), .ld_size_i(ld_size_i),
    .ld_unsigned_i(ld_unsigned_i), .addr_lo_i(addr_lo_i), .mem_rdata_i(mem_rdata_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
    .pc_wb_o(pc_wb_o), .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o),
    .fwd_data_o(fwd_data_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the instruction sitting in WB
  logic        m_valid, m_retired, m_def;
  logic [63:0] m_pc, m_alu, m_rdata, m_instret;
  logic [4:0]  m_rd;
  logic        m_we, m_ld, m_uns;
  logic [1:0]  m_size;
  logic [2:0]  m_lo;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Assemble the loaded value byte by byte, then sign-extend arithmetically
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [2:0] lo,
                                           input logic [1:0] size, input logic uns);
    int          n;
    int          idx;
    logic [63:0] val;
    logic [63:0] b;
    n = 1 << size;
    val = 64'd0;
    for (int i = 0; i < n; i++) begin
      idx = int'(lo) + i;
      b = (idx < 8) ? 64'(rdata[8*idx +: 8]) : 64'd0;
      val = val | (b << (8*i));
    end
    if (!uns && n < 8 && val[8*n-1])
      val = val - (64'd1 << (8*n));
    return val;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_valid = 0; m_retired = 0; m_def = 1; m_pc = 0; m_alu = 0; m_rdata = 0;
      m_rd = 0; m_we = 0; m_ld = 0; m_uns = 0; m_size = 0; m_lo = 0; m_instret = 0;
    end else begin
      if (m_valid && !m_retired) m_instret = m_instret + 64'd1;
      if (flush_i) begin
        m_valid = 0; m_retired = 0; m_def = 0;
      end else if (stall_i) begin
        if (m_valid) m_retired = 1;
      end else begin
        m_valid = valid_i; m_retired = 0; m_def = 1;
        m_pc = pc_i; m_rd = rd_addr_i; m_we = rd_we_i; m_alu = alu_res_i;
        m_ld = is_load_i; m_size = ld_size_i; m_uns = ld_unsigned_i;
        m_lo = addr_lo_i; m_rdata = mem_rdata_i;
      end
    end
  endtask

  task automatic check_all();
    logic        first;
    logic [63:0] exp_data;
    first = m_valid && !m_retired;
    exp_data = m_ld ? ref_load(m_rdata, m_lo, m_size, m_uns) : m_alu;
    chk_val("wr_en", 64'(wr_en_o), 64'(first && m_we && m_rd != 0));
    chk_val("pc_wb", pc_wb_o, first ? m_pc : 64'd0);
    chk_val("fwd_valid", 64'(fwd_valid_o), 64'(m_valid && m_we && m_rd != 0));
    chk_val("instret", instret_o, m_instret);
    if (m_valid || m_def) begin
      chk_val("wr_addr", 64'(wr_addr_o), 64'(m_rd));
      chk_val("fwd_addr", 64'(fwd_addr_o), 64'(m_rd));
      chk_val("wr_data", wr_data_o, exp_data);
      chk_val("fwd_data", fwd_data_o, exp_data);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_op(input logic v, input logic [63:0] pc, input logic [4:0] rd,
                        input logic we, input logic [63:0] alu, input logic ld,
                        input logic [1:0] sz, input logic un, input logic [2:0] lo,
                        input logic [63:0] rdata);
    valid_i = v; pc_i = pc; rd_addr_i = rd; rd_we_i = we; alu_res_i = alu;
    is_load_i = ld; ld_size_i = sz; ld_unsigned_i = un; addr_lo_i = lo; mem_rdata_i = rdata;
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [63:0] i0;

  initial begin
    // 1: reset held two cycles
    rst = 1; idle();
    cycle(); cycle();
    chk_val("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk_val("rst_pc_wb", pc_wb_o, 64'd0);
    chk_val("rst_instret", instret_o, 64'd0);
    chk_val("rst_fwd_valid", 64'(fwd_valid_o), 64'd0);
    rst = 0;

    // 2: ADD capture
    set_op(1, 64'h8000_0000, 5'd5, 1, 64'h1234, 0, 0, 0, 0, 0);
    cycle();
    chk_val("t2_wr_en", 64'(wr_en_o), 64'd1);
    chk_val("t2_wr_addr", 64'(wr_addr_o), 64'd5);
    chk_val("t2_wr_data", wr_data_o, 64'h1234);
    chk_val("t2_pc_wb", pc_wb_o, 64'h8000_0000);
    idle(); cycle();
    chk_val("t2_instret", instret_o, 64'd1);

    // 3: load extension cases
    set_op(1, 64'h100, 5'd6, 1, 0, 1, 2'b00, 0, 3'd3, 64'h0000_0000_80FF_0000);
    cycle();
    chk_val("t3_lb", wr_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    set_op(1, 64'h104, 5'd7, 1, 0, 1, 2'b01, 1, 3'd2, 64'h0000_0000_80FF_0000);
    cycle();
    chk_val("t3_lhu", wr_data_o, 64'h80FF);
    set_op(1, 64'h108, 5'd8, 1, 0, 1, 2'b10, 0, 3'd4, 64'h0000_0000_80FF_0000);
    cycle();
    chk_val("t3_lw", wr_data_o, 64'h0);
    set_op(1, 64'h10C, 5'd9, 1, 0, 1, 2'b11, 1, 3'd7, 64'h8877_6655_4433_2211);
    cycle();
    chk_val("t3_ld_hi", wr_data_o, 64'h88);

    // 4: capture, then stall three cycles
    idle(); cycle();
    i0 = m_instret;
    set_op(1, 64'h200, 5'd10, 1, 64'hABCD, 0, 0, 0, 0, 0);
    cycle();
    chk_val("t4_wr_en_c1", 64'(wr_en_o), 64'd1);
    stall_i = 1;
    set_op(1, 64'h300, 5'd11, 1, 64'h9999, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk_val("t4_wr_en_stall", 64'(wr_en_o), 64'd0);
      chk_val("t4_pc_wb_stall", pc_wb_o, 64'd0);
      chk_val("t4_fwd_valid", 64'(fwd_valid_o), 64'd1);
      chk_val("t4_fwd_data", fwd_data_o, 64'hABCD);
    end
    chk_val("t4_instret", instret_o, i0 + 64'd1);

    // 5: flush overrides stall and a valid capture
    stall_i = 1; flush_i = 1;
    set_op(1, 64'h400, 5'd12, 1, 64'h55, 0, 0, 0, 0, 0);
    cycle();
    chk_val("t5_wr_en", 64'(wr_en_o), 64'd0);
    chk_val("t5_pc_wb", pc_wb_o, 64'd0);
    chk_val("t5_fwd_valid", 64'(fwd_valid_o), 64'd0);

    // 6: rd=x0 still retires
    idle();
    i0 = m_instret;
    set_op(1, 64'h500, 5'd0, 1, 64'h77, 0, 0, 0, 0, 0);
    cycle();
    chk_val("t6_wr_en", 64'(wr_en_o), 64'd0);
    chk_val("t6_fwd_valid", 64'(fwd_valid_o), 64'd0);
    chk_val("t6_pc_wb", pc_wb_o, 64'h500);
    idle(); cycle();
    chk_val("t6_instret", instret_o, i0 + 64'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 59) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      stall_i = ($urandom_range(0, 3) == 0);
      set_op($urandom_range(0, 3) != 0, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
             $urandom_range(0, 4) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
             2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             3'($urandom_range(0, 7)), {$urandom, $urandom});
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
